// File: rtl/probe_click_generator.sv
// probe_click_generator: on request, waits GUARD_LEN silent strobes, emits a
// zero-DC bipolar click of PULSE_LEN samples on the step_in grid, then holds
// COOLDOWN_LEN silent strobes so room echoes decay before the next probe.
// Ports:
//   clk_in, rst_in (async, active-high), step_in (24 kHz strobe),
//   impulse_in (request level), impulse_out (one-clock marker on sample 0),
//   amp_out (signed 16-bit sample), busy (high outside IDLE).
// Optional build macro PROBE_TAPER_EN halves the magnitude of the first and
// last sample of each click half to reduce speaker ringing.
module probe_click_generator #(
   parameter int PULSE_LEN    = 8,
   parameter int AMPLITUDE    = 16384,
   parameter int GUARD_LEN    = 4,
   parameter int COOLDOWN_LEN = 16
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               step_in,
   input  logic               impulse_in,
   output logic               impulse_out,
   output logic signed [15:0] amp_out,
   output logic               busy
);

   localparam int MAX_GP = (GUARD_LEN > PULSE_LEN) ? GUARD_LEN : PULSE_LEN;
   localparam int MAX_L  = (MAX_GP > COOLDOWN_LEN) ? MAX_GP : COOLDOWN_LEN;
   localparam int CW     = $clog2(MAX_L + 1);
   localparam int HALF   = PULSE_LEN / 2;

   localparam logic signed [15:0] AMP_POS = 16'(AMPLITUDE);

   typedef enum logic [1:0] {
      IDLE,
      GUARD,
      PULSE,
      COOLDOWN
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic signed [15:0]   amp_q, amp_d;
   logic                 imp_q, imp_d;
   logic                 busy_q, busy_d;

   // Click sample k: positive first half, negative second half.
   function automatic logic signed [15:0] sample_at(input logic [CW-1:0] k);
      logic signed [15:0] mag;
      mag = AMP_POS;
`ifdef PROBE_TAPER_EN
      if (k == CW'(0) || k == CW'(HALF - 1) ||
          k == CW'(HALF) || k == CW'(PULSE_LEN - 1))
         mag = AMP_POS >>> 1;
`endif
      return (k < CW'(HALF)) ? mag : -mag;
   endfunction

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         amp_q   <= '0;
         imp_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         amp_q   <= amp_d;
         imp_q   <= imp_d;
         busy_q  <= busy_d;
      end
   end

   // cnt_q meaning per state:
   //   GUARD    - guard strobes elapsed
   //   PULSE    - index of the next sample to drive (PULSE_LEN = click done)
   //   COOLDOWN - cooldown strobes elapsed (the click-ending strobe is #1)
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      amp_d   = amp_q;
      imp_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            // A coincident step_in is deliberately not counted here.
            if (impulse_in)
               state_d = GUARD;
         end
         GUARD: begin
            if (step_in) begin
               if (cnt_q == CW'(GUARD_LEN)) begin
                  amp_d   = sample_at('0);
                  imp_d   = 1'b1;
                  state_d = PULSE;
                  cnt_d   = CW'(1);
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         PULSE: begin
            if (step_in) begin
               if (cnt_q == CW'(PULSE_LEN)) begin
                  amp_d = '0;
                  if (COOLDOWN_LEN == 1) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end else begin
                     state_d = COOLDOWN;
                     cnt_d   = CW'(1);
                  end
               end else begin
                  amp_d = sample_at(cnt_q);
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         COOLDOWN: begin
            if (step_in) begin
               if (cnt_q == CW'(COOLDOWN_LEN - 1)) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   assign impulse_out = imp_q;
   assign amp_out     = amp_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_probe_click_generator.sv
// Testbench for probe_click_generator: default instance plus a
// GUARD_LEN=0 / PULSE_LEN=2 / COOLDOWN_LEN=1 instance, strobe-count model.
module tb_probe_click_generator;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic step = 1'b0;
   logic req = 1'b0;

   logic               imp0, busy0, imp1, busy1;
   logic signed [15:0] amp0, amp1;

   int total = 0;
   int bad = 0;

   probe_click_generator dut0 (
      .clk_in(clk), .rst_in(rst), .step_in(step), .impulse_in(req),
      .impulse_out(imp0), .amp_out(amp0), .busy(busy0)
   );

   probe_click_generator #(
      .PULSE_LEN(2), .AMPLITUDE(16384), .GUARD_LEN(0), .COOLDOWN_LEN(1)
   ) dut1 (
      .clk_in(clk), .rst_in(rst), .step_in(step), .impulse_in(req),
      .impulse_out(imp1), .amp_out(amp1), .busy(busy1)
   );

   always #5 clk = ~clk;

   function automatic int g_of(int i); return (i == 0) ? 4 : 0; endfunction
   function automatic int p_of(int i); return (i == 0) ? 8 : 2; endfunction
   function automatic int c_of(int i); return (i == 0) ? 16 : 1; endfunction

   // Click shape straight from the waveform rules.
   function automatic logic signed [15:0] shape(int k, int p);
      int h, mag;
      h = p / 2;
      mag = 16384;
`ifdef PROBE_TAPER_EN
      if (k == 0 || k == h - 1 || k == h || k == p - 1)
         mag = 8192;
`endif
      return (k < h) ? 16'(mag) : 16'(-mag);
   endfunction

   // Model: count strobes since acceptance; outputs follow from that count.
   bit                 m_idle[2] = '{1'b1, 1'b1};
   int                 m_n[2] = '{0, 0};
   logic signed [15:0] m_amp[2] = '{16'sd0, 16'sd0};
   bit                 m_imp[2] = '{1'b0, 1'b0};

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            m_idle[i] = 1'b1; m_n[i] = 0;
            m_amp[i] = '0; m_imp[i] = 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            m_imp[i] = 1'b0;
            if (m_idle[i]) begin
               if (req) begin
                  m_idle[i] = 1'b0;
                  m_n[i] = 0;
               end
            end else if (step) begin
               m_n[i]++;
               if (m_n[i] > g_of(i) && m_n[i] <= g_of(i) + p_of(i))
                  m_amp[i] = shape(m_n[i] - g_of(i) - 1, p_of(i));
               else
                  m_amp[i] = '0;
               m_imp[i] = (m_n[i] == g_of(i) + 1);
               if (m_n[i] == g_of(i) + p_of(i) + c_of(i))
                  m_idle[i] = 1'b1;
            end
         end
      end
   end

   task automatic test_reset();
      #2;
      total++;
      if (amp0 !== 16'sd0 || imp0 !== 1'b0 || busy0 !== 1'b0) begin
         bad++;
         $display("FAIL reset0 amp=%0d imp=%b busy=%b want 0 0 0",
                  amp0, imp0, busy0);
      end
      total++;
      if (amp1 !== 16'sd0 || imp1 !== 1'b0 || busy1 !== 1'b0) begin
         bad++;
         $display("FAIL reset1 amp=%0d imp=%b busy=%b want 0 0 0",
                  amp1, imp1, busy1);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single_probe();
      int strobes = 0, marks = 0;
      bit seen = 1'b0, done = 1'b0, pre_busy;
      for (int cyc = 0; cyc < 400 && !done; cyc++) begin
         @(negedge clk);
         step = (cyc % 4 == 3);
         req = !seen;
         pre_busy = busy0;
         @(posedge clk);
         #1;
         if (step && pre_busy) strobes++;
         if (imp0) marks++;
         total++;
         if (amp0 !== m_amp[0]) begin
            bad++;
            $display("FAIL single_amp cyc=%0d got=%0d want=%0d",
                     cyc, amp0, m_amp[0]);
         end
         total++;
         if (imp0 !== m_imp[0] || busy0 !== !m_idle[0]) begin
            bad++;
            $display("FAIL single_ctl cyc=%0d imp=%b busy=%b want %b %b",
                     cyc, imp0, busy0, m_imp[0], !m_idle[0]);
         end
         if (m_imp[0]) seen = 1'b1;
         if (seen && m_idle[0]) done = 1'b1;
      end
      total++;
      if (!done || marks !== 1 || strobes !== 28) begin
         bad++;
         $display("FAIL single_len done=%b marks=%0d strobes=%0d want 1 1 28",
                  done, marks, strobes);
      end
      step = 1'b0;
   endtask

   task automatic test_back_to_back();
      int strobes = 0, last = -1, gaps = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         step = (cyc % 4 == 1);
         req = 1'b1;
         @(posedge clk);
         #1;
         if (step) strobes++;
         total++;
         if (amp0 !== m_amp[0] || imp0 !== m_imp[0]
             || busy0 !== !m_idle[0]) begin
            bad++;
            $display("FAIL b2b cyc=%0d amp=%0d imp=%b busy=%b want %0d %b %b",
                     cyc, amp0, imp0, busy0, m_amp[0], m_imp[0], !m_idle[0]);
         end
         if (imp0) begin
            if (last >= 0) begin
               gaps++;
               total++;
               if (strobes - last !== 28) begin
                  bad++;
                  $display("FAIL b2b_gap got=%0d want=28", strobes - last);
               end
            end
            last = strobes;
         end
      end
      total++;
      if (gaps < 2) begin
         bad++;
         $display("FAIL b2b_count got=%0d want>=2", gaps);
      end
      req = 1'b0;
      for (int cyc = 0; cyc < 200 && !m_idle[0]; cyc++) begin
         @(negedge clk);
         step = (cyc % 4 == 0);
         @(posedge clk);
         #1;
      end
      step = 1'b0;
      total++;
      if (busy0 !== 1'b0 || !m_idle[0]) begin
         bad++;
         $display("FAIL b2b_drain busy=%b want 0", busy0);
      end
   endtask

   task automatic test_drop();
      int marks = 0;
      bit done = 1'b0;
      for (int cyc = 0; cyc < 600 && !done; cyc++) begin
         @(negedge clk);
         step = ($urandom_range(0, 2) == 0);
         req = (cyc == 0);
         @(posedge clk);
         #1;
         if (imp0) marks++;
         total++;
         if (amp0 !== m_amp[0] || imp0 !== m_imp[0]
             || busy0 !== !m_idle[0]) begin
            bad++;
            $display("FAIL drop cyc=%0d amp=%0d imp=%b busy=%b want %0d %b %b",
                     cyc, amp0, imp0, busy0, m_amp[0], m_imp[0], !m_idle[0]);
         end
         if (cyc > 0 && m_idle[0]) done = 1'b1;
      end
      total++;
      if (!done || marks !== 1) begin
         bad++;
         $display("FAIL drop_marks done=%b marks=%0d want 1 1", done, marks);
      end
      step = 1'b0;
   endtask

   task automatic test_async_reset();
      bit inpulse = 1'b0;
      for (int cyc = 0; cyc < 200 && !inpulse; cyc++) begin
         @(negedge clk);
         step = (cyc % 2 == 1);
         req = 1'b1;
         @(posedge clk);
         #1;
         if (!m_idle[0] && m_n[0] == 6) inpulse = 1'b1;
      end
      total++;
      if (!inpulse || busy0 !== 1'b1 || amp0 === 16'sd0) begin
         bad++;
         $display("FAIL areset_pre busy=%b amp=%0d want busy 1 amp!=0",
                  busy0, amp0);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (amp0 !== 16'sd0 || imp0 !== 1'b0 || busy0 !== 1'b0) begin
         bad++;
         $display("FAIL areset amp=%0d imp=%b busy=%b want 0 0 0",
                  amp0, imp0, busy0);
      end
      req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         step = ($urandom_range(0, 1) == 1);
         @(posedge clk);
         #1;
         total++;
         if (busy0 !== 1'b0 || amp0 !== 16'sd0 || busy1 !== 1'b0) begin
            bad++;
            $display("FAIL areset_idle cyc=%0d busy=%b amp=%0d want 0 0",
                     cyc, busy0, amp0);
         end
      end
      step = 1'b0;
   endtask

   task automatic test_guard0();
      int gap;
      @(negedge clk);
      req = 1'b1;
      step = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (amp1 !== 16'sd0 || imp1 !== 1'b0 || busy1 !== 1'b1) begin
         bad++;
         $display("FAIL g0_accept amp=%0d imp=%b busy=%b want 0 0 1",
                  amp1, imp1, busy1);
      end
      req = 1'b0;
      for (int s = 0; s < 4; s++) begin
         gap = $urandom_range(1, 4);
         for (int c = 0; c < gap; c++) begin
            @(negedge clk);
            step = (c == gap - 1);
            @(posedge clk);
            #1;
            total++;
            if (amp1 !== m_amp[1] || imp1 !== m_imp[1]
                || busy1 !== !m_idle[1]) begin
               bad++;
               $display("FAIL g0 s=%0d amp=%0d imp=%b busy=%b want %0d %b %b",
                        s, amp1, imp1, busy1, m_amp[1], m_imp[1], !m_idle[1]);
            end
            if (s == 0 && step) begin
               total++;
               if (amp1 !== shape(0, 2) || imp1 !== 1'b1) begin
                  bad++;
                  $display("FAIL g0_first amp=%0d imp=%b want %0d 1",
                           amp1, imp1, shape(0, 2));
               end
            end
         end
      end
      step = 1'b0;
      total++;
      if (busy1 !== 1'b0) begin
         bad++;
         $display("FAIL g0_end busy=%b want 0", busy1);
      end
   endtask

   initial begin
      test_reset();
      test_single_probe();
      test_back_to_back();
      test_drop();
      test_async_reset();
      test_guard0();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/probe_click_generator.md
# probe_click_generator

Speaker-side probe source for the speed-of-sound ranging path. On request it waits a silent guard interval, then emits a zero-DC bipolar click on the 24 kHz sample grid. It pulses a one-clock marker on the exact clock the click's first sample is driven, and then holds a silent cooldown so room echoes decay before the next probe. Its request/acknowledge pair is the source end of the handshake that the distance calculator drives. The calculator starts its delay count at the marker.

## Interface
- `PULSE_LEN`, default 8: click length in samples; even, at least 2.
- `AMPLITUDE`, default 16384: click peak magnitude; 1..32767.
- `GUARD_LEN`, default 4: silent samples before the click; at least 0.
- `COOLDOWN_LEN`, default 16: silent samples after the click; at least 1.

- `clk_in`  input  1  system clock.
- `rst_in`  input  1  reset; asynchronous, active-high.
- `step_in`  input  1  one-clock 24 kHz sample strobe.
- `impulse_in`  input  1  probe request (level).
- `impulse_out`  output  1  one-clock marker on the clock where click sample 0 is driven.
- `amp_out`  output  signed 16  audio sample to the speaker path.
- `busy`  output  1  high in every state except IDLE.

## Operation
- States and transitions:
  - IDLE: if `impulse_in` is high on any clock, go to GUARD. The sample counter clears.
  - GUARD: count `step_in` strobes. Once `GUARD_LEN` strobes have elapsed, the next strobe drives sample 0, pulses `impulse_out` and enters PULSE.
  - PULSE: each strobe drives the next sample. The strobe after sample `PULSE_LEN-1` drives 0 and enters COOLDOWN; that strobe counts as cooldown strobe 1.
  - COOLDOWN: on the `COOLDOWN_LEN`-th cooldown strobe, return to IDLE.
- Click shape for sample index k = 0..`PULSE_LEN-1`:
  - `+AMPLITUDE` for k < `PULSE_LEN/2`.
  - `-AMPLITUDE` otherwise.
  - The shape has zero net DC.
- Request semantics:
  - The request is latched at acceptance. Dropping `impulse_in` during GUARD, PULSE or COOLDOWN does not abort the probe.
  - If `impulse_in` is still high on return to IDLE, a new probe starts. This covers the consumer's timeout-retry.
- Width rules:
  - The sample counter is `$clog2(max(GUARD_LEN, PULSE_LEN, COOLDOWN_LEN)+1)` bits.
  - `-AMPLITUDE` is formed in 16-bit signed arithmetic with no overflow, given the allowed range.
- `amp_out` is 0 in IDLE, GUARD and COOLDOWN.

## Timing
- Reset values: `amp_out`=0, `impulse_out`=0, `busy`=0, state IDLE, counter 0.
- Asynchronous reset mid-probe drops every output to these values immediately, with no clock needed.
- All outputs are registered.
- `amp_out` changes only on clocks where `step_in`=1, or on reset.
- `impulse_out` is high for exactly one clock per probe, on the same clock `amp_out` takes sample 0.
- Acceptance: `impulse_in` high in IDLE at clock t gives `busy`=1 at t+1.
- A `step_in` coincident with acceptance is not counted as a guard strobe.
- `GUARD_LEN`=0: the first strobe after acceptance drives sample 0.
- Latency: sample 0 appears on the (`GUARD_LEN`+1)-th strobe after acceptance. `busy` falls on the (`GUARD_LEN`+`PULSE_LEN`+`COOLDOWN_LEN`)-th strobe.
- `impulse_in` rising while `busy`: ignored unless still high when IDLE is reached.

## Configuration
- `PROBE_TAPER_EN` defined:
  - Samples k=0, `PULSE_LEN/2-1`, `PULSE_LEN/2` and `PULSE_LEN-1` are driven at half magnitude, `±(AMPLITUDE>>>1)`, with the sign of their half. This reduces speaker ringing.
  - With `PULSE_LEN`=2, both samples are tapered.
- `PROBE_TAPER_EN` undefined: full-magnitude rectangular halves. There is no taper logic in the netlist.

## Test plan
- Default parameters, `step_in` every 4 clocks, one request held until `impulse_out`:
  - `amp_out` is 0 for 4 strobes, then 16384 x4, then -16384 x4, then 0.
  - `impulse_out` is a single clock aligned with the first 16384.
  - `busy` falls 28 strobes after acceptance.
- `PROBE_TAPER_EN` defined, defaults: click is 8192, 16384, 16384, 8192, -8192, -16384, -16384, -8192.
- `impulse_in` held high continuously: back-to-back probes, each preceded by 4 guard zeros. `impulse_out` pulses are spaced exactly 28 strobes apart.
- `impulse_in` dropped one clock after acceptance: the full probe still completes with an identical waveform and marker.
- `rst_in` asserted during PULSE, between clock edges: `amp_out`=0, `busy`=0, `impulse_out`=0 at once. After release with `impulse_in` low, the block stays IDLE.
- `GUARD_LEN`=0 and `impulse_in` coincident with `step_in`:
  - The coincident strobe yields no sample.
  - The next strobe drives 16384 with `impulse_out`=1.
